multi_cycle_controller: RTL and testbench

Control FSM for the multi-cycle RV32I core, replacing the single-cycle control unit. It sequences a shared datapath (one ALU, one unified instruction/data memory, IR, A/B/ALUOut/MDR registers) through the IF/ID/EX/MEM/WB states. Memory accesses use a variable-latency ready handshake. The block also keeps a retired-instruction counter.

---
 rtl/multi_cycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB over a shared
// datapath with a variable-latency memory handshake and counts retired instructions.
module multi_cycle_controller #(
   parameter int OPC_WIDTH = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OPC_WIDTH-1:0] opcode,
   input  logic                 bcond,
   input  logic                 halt_req,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic [1:0]           pc_source,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic [1:0]           wb_sel,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 is_halted,
   output logic [31:0]          instret
);

   localparam logic [OPC_WIDTH-1:0] OP_R      = OPC_WIDTH'(7'b0110011);
   localparam logic [OPC_WIDTH-1:0] OP_I      = OPC_WIDTH'(7'b0010011);
   localparam logic [OPC_WIDTH-1:0] OP_LOAD   = OPC_WIDTH'(7'b0000011);
   localparam logic [OPC_WIDTH-1:0] OP_STORE  = OPC_WIDTH'(7'b0100011);
   localparam logic [OPC_WIDTH-1:0] OP_BRANCH = OPC_WIDTH'(7'b1100011);
   localparam logic [OPC_WIDTH-1:0] OP_JAL    = OPC_WIDTH'(7'b1101111);
   localparam logic [OPC_WIDTH-1:0] OP_JALR   = OPC_WIDTH'(7'b1100111);
   localparam logic [OPC_WIDTH-1:0] OP_SYSTEM = OPC_WIDTH'(7'b1110011);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_retire;
   logic        w_known;
   logic [31:0] r_instret;

   // Opcodes that need an EX cycle; anything else decoded in ID retires as a NOP.
   always_comb begin
      w_known = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: w_known = 1'b1;
         default:                                                   w_known = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IF;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      pc_write  = 1'b0;
      pc_source = 2'd0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      is_halted = 1'b0;

      case (r_state)
         S_IF: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               w_next   = S_ID;
            end
         end

         S_ID: begin
            alu_src_b = 2'd2;
            if (opcode == OP_SYSTEM && halt_req) begin
               w_next = S_HALT;
            end else if (opcode == OP_SYSTEM || !w_known) begin
               pc_write = 1'b1;
               w_retire = 1'b1;
               w_next   = S_IF;
            end else begin
               w_next = S_EX;
            end
         end

         S_EX: begin
            w_next = S_IF;
            case (opcode)
               OP_R: begin
                  alu_src_a = 1'b1;
                  alu_op    = 2'd2;
                  w_next    = S_WB;
               end
               OP_I: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  alu_op    = 2'd2;
                  w_next    = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  w_next    = S_MEM;
               end
               OP_BRANCH: begin
                  alu_src_a = 1'b1;
                  alu_op    = 2'd1;
                  pc_write  = 1'b1;
                  pc_source = bcond ? 2'd2 : 2'd0;
                  w_retire  = 1'b1;
               end
               OP_JAL: begin
                  pc_write  = 1'b1;
                  pc_source = 2'd2;
                  reg_write = 1'b1;
                  wb_sel    = 2'd2;
                  w_retire  = 1'b1;
               end
               OP_JALR: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd2;
                  pc_write  = 1'b1;
                  pc_source = 2'd1;
                  reg_write = 1'b1;
                  wb_sel    = 2'd2;
                  w_retire  = 1'b1;
               end
               default: w_next = S_IF;
            endcase
         end

         S_MEM: begin
            i_or_d = 1'b1;
            if (opcode == OP_LOAD) begin
               mem_read = 1'b1;
               if (mem_ready) w_next = S_WB;
            end else if (opcode == OP_STORE) begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  pc_write = 1'b1;
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end
            end else begin
               w_next = S_IF;
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
            w_retire  = 1'b1;
            w_next    = S_IF;
         end

         S_HALT: is_halted = 1'b1;

         default: w_next = S_IF;
      endcase

      // Reset is asynchronous, so the enables must drop combinationally, not at the next edge.
      if (!reset) begin
         w_retire  = 1'b0;
         pc_write  = 1'b0;
         pc_source = 2'd0;
         i_or_d    = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         wb_sel    = 2'd0;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         alu_op    = 2'd0;
         is_halted = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        r_instret <= 32'd0;
      else if (w_retire) r_instret <= r_instret + 32'd1;
   end

   assign instret = r_instret;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: one task per instruction class, inline checks.
module tb_multi_cycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        bcond;
   logic        halt_req;
   logic        mem_ready;
   logic        pc_write;
   logic [1:0]  pc_source;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        is_halted;
   logic [31:0] instret;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_ir = 32'd0;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   always #5 clk = ~clk;

   multi_cycle_controller #(.OPC_WIDTH(7)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .is_halted(is_halted), .instret(instret)
   );

   // Every output except instret, packed for all-zero checks.
   wire [15:0] w_outs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                         reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};

   // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b0; opcode = OP_R; bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b1;
      repeat (3) tick();
      #1;
      n_chk++;
      if (w_outs !== 16'd0 || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: outs=%h instret=%h, required 0/0", w_outs, instret);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (mem_read !== 1'b1 || i_or_d !== 1'b0 || dut.r_state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_release_if: mem_read=%b i_or_d=%b state=%0d, required 1/0/0",
                  mem_read, i_or_d, dut.r_state);
      end
   endtask

   task automatic test_rtype();
      opcode = OP_R; mem_ready = 1'b1; #1;
      n_chk++;
      if (ir_write !== 1'b1 || mem_read !== 1'b1) begin
         n_fail++; $display("FAIL rtype_if: ir_write=%b mem_read=%b, required 1/1", ir_write, mem_read);
      end
      tick(); #1;   // ID, mem_ready still high and must be ignored
      n_chk++;
      if (dut.r_state !== 3'd1 || alu_src_b !== 2'd2 || alu_src_a !== 1'b0 || pc_write !== 1'b0 ||
          reg_write !== 1'b0 || ir_write !== 1'b0) begin
         n_fail++; $display("FAIL rtype_id: state=%0d outs=%h, required ID with alu_src_b=2 only",
                            dut.r_state, w_outs);
      end
      tick(); #1;
      n_chk++;
      if (dut.r_state !== 3'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || alu_op !== 2'd2 ||
          reg_write !== 1'b0 || pc_write !== 1'b0) begin
         n_fail++; $display("FAIL rtype_ex: state=%0d outs=%h, required EX a=1 b=0 op=2", dut.r_state, w_outs);
      end
      tick(); #1;
      n_chk++;
      if (dut.r_state !== 3'd4 || reg_write !== 1'b1 || pc_write !== 1'b1 || pc_source !== 2'd0 ||
          wb_sel !== 2'd0 || instret !== exp_ir) begin
         n_fail++; $display("FAIL rtype_wb: state=%0d outs=%h instret=%h, required WB rw=1 pw=1 ws=0 ir=%h",
                            dut.r_state, w_outs, instret, exp_ir);
      end
      exp_ir = exp_ir + 32'd1;
      tick(); #1;
      n_chk++;
      if (dut.r_state !== 3'd0 || instret !== exp_ir) begin
         n_fail++; $display("FAIL rtype_retire: state=%0d instret=%h, required 0/%h", dut.r_state, instret, exp_ir);
      end
   endtask

   task automatic test_load();
      int cycles = 0;
      int pulses = 0;
      bit stable = 1'b1;
      opcode = OP_LOAD; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3); #1;
         if (mem_read !== 1'b1 || i_or_d !== 1'b0 || mem_write !== 1'b0) stable = 1'b0;
         if (ir_write === 1'b1) pulses++;
         cycles++; tick();
      end
      mem_ready = 1'b0; #1; cycles++;   // ID
      tick(); #1; cycles++;             // EX
      n_chk++;
      if (dut.r_state !== 3'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_op !== 2'd0) begin
         n_fail++; $display("FAIL load_ex: state=%0d outs=%h, required EX a=1 b=2 op=0", dut.r_state, w_outs);
      end
      for (int i = 0; i < 3; i++) begin
         tick(); mem_ready = (i == 2); #1; cycles++;
         if (dut.r_state !== 3'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1 || mem_write !== 1'b0 ||
             pc_write !== 1'b0) stable = 1'b0;
         if (ir_write === 1'b1) pulses++;
      end
      tick(); mem_ready = 1'b0; #1; cycles++;
      n_chk++;
      if (dut.r_state !== 3'd4 || wb_sel !== 2'd1 || reg_write !== 1'b1 || pc_write !== 1'b1) begin
         n_fail++; $display("FAIL load_wb: state=%0d outs=%h, required WB with wb_sel=1", dut.r_state, w_outs);
      end
      n_chk++;
      if (!stable || pulses != 1) begin
         n_fail++; $display("FAIL load_handshake: stable=%0b ir_write pulses=%0d, required 1/1", stable, pulses);
      end
      exp_ir = exp_ir + 32'd1;
      tick(); #1;
      n_chk++;
      if (cycles != 10 || dut.r_state !== 3'd0 || instret !== exp_ir) begin
         n_fail++; $display("FAIL load_retire: cycles=%0d state=%0d instret=%h, required 10/0/%h",
                            cycles, dut.r_state, instret, exp_ir);
      end
   endtask

   task automatic test_store();
      opcode = OP_STORE; mem_ready = 1'b1; #1;
      tick(); mem_ready = 1'b0; #1;
      tick(); #1;
      tick(); #1;   // MEM, waiting
      n_chk++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || i_or_d !== 1'b1 || pc_write !== 1'b0 ||
          instret !== exp_ir) begin
         n_fail++; $display("FAIL store_wait: outs=%h instret=%h, required mw=1 mr=0 iod=1 pw=0", w_outs, instret);
      end
      mem_ready = 1'b1; #1;
      n_chk++;
      if (mem_write !== 1'b1 || pc_write !== 1'b1 || pc_source !== 2'd0 || reg_write !== 1'b0) begin
         n_fail++; $display("FAIL store_done: outs=%h, required mw=1 pw=1 ps=0 rw=0", w_outs);
      end
      exp_ir = exp_ir + 32'd1;
      tick(); #1;
      n_chk++;
      if (dut.r_state !== 3'd0 || instret !== exp_ir) begin
         n_fail++; $display("FAIL store_retire: state=%0d instret=%h, required 0/%h", dut.r_state, instret, exp_ir);
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 2; k++) begin
         opcode = OP_BRANCH; bcond = (k == 0); mem_ready = 1'b1; #1;
         tick(); mem_ready = 1'b0; #1;
         tick(); #1;
         n_chk++;
         if (dut.r_state !== 3'd2 || pc_write !== 1'b1 || pc_source !== ((k == 0) ? 2'd2 : 2'd0) ||
             alu_op !== 2'd1 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL branch_ex%0d: state=%0d outs=%h bcond=%b", k, dut.r_state, w_outs, bcond);
         end
         exp_ir = exp_ir + 32'd1;
         tick(); #1;
         n_chk++;
         if (dut.r_state !== 3'd0 || instret !== exp_ir) begin
            n_fail++; $display("FAIL branch_retire%0d: state=%0d instret=%h, required 0/%h",
                               k, dut.r_state, instret, exp_ir);
         end
      end
      bcond = 1'b0;
   endtask

   task automatic test_jump();
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? OP_JAL : OP_JALR; mem_ready = 1'b1; #1;
         tick(); mem_ready = 1'b0; #1;
         tick(); #1;
         n_chk++;
         if (reg_write !== 1'b1 || wb_sel !== 2'd2 || pc_write !== 1'b1 ||
             pc_source !== ((k == 0) ? 2'd2 : 2'd1) ||
             alu_src_b !== ((k == 0) ? 2'd0 : 2'd2) || alu_src_a !== (k == 1)) begin
            n_fail++; $display("FAIL jump_ex%0d: outs=%h, required rw=1 ws=2 pw=1", k, w_outs);
         end
         exp_ir = exp_ir + 32'd1;
         tick(); #1;
         n_chk++;
         if (dut.r_state !== 3'd0 || instret !== exp_ir) begin
            n_fail++; $display("FAIL jump_no_wb%0d: state=%0d instret=%h, required 0/%h",
                               k, dut.r_state, instret, exp_ir);
         end
      end
   endtask

   task automatic test_id_retire();
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? OP_LUI : OP_SYSTEM; halt_req = 1'b0; mem_ready = 1'b1; #1;
         tick(); mem_ready = 1'b0; #1;
         n_chk++;
         if (pc_write !== 1'b1 || pc_source !== 2'd0 || reg_write !== 1'b0 || alu_src_b !== 2'd2) begin
            n_fail++; $display("FAIL id_retire%0d: outs=%h, required pw=1 ps=0 rw=0 b=2", k, w_outs);
         end
         exp_ir = exp_ir + 32'd1;
         tick(); #1;
         n_chk++;
         if (dut.r_state !== 3'd0 || instret !== exp_ir) begin
            n_fail++; $display("FAIL id_retire_cnt%0d: state=%0d instret=%h, required 0/%h",
                               k, dut.r_state, instret, exp_ir);
         end
      end
   endtask

   task automatic test_wrap();
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      opcode = OP_LUI; mem_ready = 1'b1; #1;
      tick(); mem_ready = 1'b0; #1;
      n_chk++;
      if (instret !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL wrap_preload: instret=%h, required ffffffff", instret);
      end
      tick(); #1;
      n_chk++;
      if (instret !== 32'd0) begin
         n_fail++; $display("FAIL wrap: instret=%h, required 00000000", instret);
      end
      exp_ir = 32'd0;
   endtask

   task automatic test_reset_mid();
      force dut.r_instret = 32'hFFFF_FFFF;
      #1;
      release dut.r_instret;
      opcode = OP_LOAD; mem_ready = 1'b1; #1;
      tick(); mem_ready = 1'b0; #1;
      tick(); #1;
      tick(); #1;   // MEM wait
      n_chk++;
      if (dut.r_state !== 3'd3 || mem_read !== 1'b1) begin
         n_fail++; $display("FAIL rmid_setup: state=%0d mem_read=%b, required 3/1", dut.r_state, mem_read);
      end
      mem_ready = 1'b1; reset = 1'b0; #1;
      n_chk++;
      if (w_outs !== 16'd0 || instret !== 32'd0) begin
         n_fail++; $display("FAIL rmid_abort: outs=%h instret=%h, required 0/0", w_outs, instret);
      end
      tick(); #1;
      n_chk++;
      if (w_outs !== 16'd0 || instret !== 32'd0 || dut.r_state !== 3'd0) begin
         n_fail++; $display("FAIL rmid_hold: outs=%h instret=%h state=%0d, required 0/0/0",
                            w_outs, instret, dut.r_state);
      end
      reset = 1'b1; mem_ready = 1'b0; #1;
      exp_ir = 32'd0;
   endtask

   task automatic test_halt();
      bit ok = 1'b1;
      opcode = OP_SYSTEM; halt_req = 1'b1; mem_ready = 1'b1; #1;
      tick(); mem_ready = 1'b0; #1;
      n_chk++;
      if (pc_write !== 1'b0 || reg_write !== 1'b0 || is_halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_id: outs=%h, required no enables", w_outs);
      end
      tick(); halt_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0]; #1;
         if (w_outs !== 16'h0001 || instret !== exp_ir || dut.r_state !== 3'd5) ok = 1'b0;
         tick();
      end
      n_chk++;
      if (!ok) begin
         n_fail++; $display("FAIL halt_hold: outs=%h instret=%h state=%0d, required 0001/%h/5",
                            w_outs, instret, dut.r_state, exp_ir);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_store();
      test_branch();
      test_jump();
      test_id_retire();
      test_wrap();
      test_rtype();
      test_reset_mid();
      test_rtype();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
